// File: rtl/fp_upconvert_pipe.sv
// Two-stage exact float upconvert (e.g. binary16 -> binary32), valid/ready.
// Define FP_UPCONVERT_DAZ_EN to flush denormal inputs to signed zero.
module fp_upconvert_pipe #(
   parameter int SRC_EXP = 5,
   parameter int SRC_MAN = 10,
   parameter int DST_EXP = 8,
   parameter int DST_MAN = 23,
   localparam int SRC_W = 1 + SRC_EXP + SRC_MAN,
   localparam int DST_W = 1 + DST_EXP + DST_MAN
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [SRC_W-1:0] in_data,
   input  logic             in_valid,
   output logic             in_ready,
   output logic [DST_W-1:0] out_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             out_invalid
);

   localparam int PAD = DST_MAN - SRC_MAN;
   localparam int DELTA = (2 ** (DST_EXP - 1)) - (2 ** (SRC_EXP - 1));
   localparam logic [DST_EXP-1:0] DELTA_V = DST_EXP'(DELTA);
   localparam logic [DST_MAN-1:0] QUIET = DST_MAN'(1) << (DST_MAN - 1);

   typedef enum logic [2:0] {
      CL_ZERO, CL_DEN, CL_NORM, CL_INF, CL_NAN
   } cls_e;

   function automatic logic [DST_MAN-1:0] pad_man(
      input logic [SRC_MAN-1:0] m
   );
      return DST_MAN'(m) << PAD;
   endfunction

   logic               s1_valid;
   logic               s2_valid;
   logic               s1_adv;
   logic               s2_adv;
   logic               s1_sign;
   logic [SRC_EXP-1:0] s1_exp;
   logic [SRC_MAN-1:0] s1_mant;
   cls_e               s1_class;

   logic               in_sign;
   logic [SRC_EXP-1:0] in_exp;
   logic [SRC_MAN-1:0] in_mant;
   logic               exp_zero;
   logic               exp_max;
   logic               mant_zero;
   cls_e               in_class;

   logic [DST_EXP-1:0] asm_exp;
   logic [DST_MAN-1:0] asm_mant;
   logic               asm_inv;

   assign s2_adv    = !s2_valid || out_ready;
   assign s1_adv    = !s1_valid || s2_adv;
   assign in_ready  = s1_adv;
   assign out_valid = s2_valid;

   assign in_sign   = in_data[SRC_W-1];
   assign in_exp    = in_data[SRC_W-2 -: SRC_EXP];
   assign in_mant   = in_data[SRC_MAN-1:0];
   assign exp_zero  = (in_exp == '0);
   assign exp_max   = &in_exp;
   assign mant_zero = (in_mant == '0);

   always_comb begin
      in_class = CL_NORM;
      unique case (1'b1)
         exp_zero && mant_zero:  in_class = CL_ZERO;
`ifdef FP_UPCONVERT_DAZ_EN
         exp_zero && !mant_zero: in_class = CL_ZERO;
`else
         exp_zero && !mant_zero: in_class = CL_DEN;
`endif
         exp_max && mant_zero:   in_class = CL_INF;
         exp_max && !mant_zero:  in_class = CL_NAN;
         default:                in_class = CL_NORM;
      endcase
   end

`ifndef FP_UPCONVERT_DAZ_EN
   localparam int LZ_W = $clog2(SRC_MAN + 1);

   logic [LZ_W-1:0]    in_lz;
   logic [LZ_W-1:0]    s1_shift;
   logic [SRC_MAN-1:0] den_m;

   // Highest set bit wins, so scan upward and let later hits overwrite.
   always_comb begin
      in_lz = '0;
      for (int i = 0; i < SRC_MAN; i++) begin
         if (in_mant[i]) in_lz = LZ_W'(SRC_MAN - 1 - i);
      end
   end

   always_ff @(posedge clk) begin
      if (s1_adv && in_valid) s1_shift <= in_lz;
   end

   // Shift out the leading one too; it becomes the implicit bit.
   assign den_m = (s1_mant << s1_shift) << 1;
`endif

   always_ff @(posedge clk) begin
      if (s1_adv && in_valid) begin
         s1_sign  <= in_sign;
         s1_exp   <= in_exp;
         s1_mant  <= in_mant;
         s1_class <= in_class;
      end
   end

   always_comb begin
      asm_exp  = '0;
      asm_mant = '0;
      asm_inv  = 1'b0;
      unique case (s1_class)
         CL_ZERO: begin
            asm_exp  = '0;
            asm_mant = '0;
         end
         CL_INF: begin
            asm_exp = '1;
         end
         CL_NAN: begin
            asm_exp  = '1;
            asm_mant = pad_man(s1_mant) | QUIET;
            asm_inv  = !s1_mant[SRC_MAN-1];
         end
         CL_NORM: begin
            asm_exp  = DST_EXP'(s1_exp) + DELTA_V;
            asm_mant = pad_man(s1_mant);
         end
`ifndef FP_UPCONVERT_DAZ_EN
         CL_DEN: begin
            asm_exp  = DELTA_V - DST_EXP'(s1_shift);
            asm_mant = pad_man(den_m);
         end
`endif
         default: begin
            asm_exp  = '0;
            asm_mant = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid    <= 1'b0;
         s2_valid    <= 1'b0;
         out_data    <= '0;
         out_invalid <= 1'b0;
      end else begin
         if (s1_adv) s1_valid <= in_valid;
         if (s2_adv) s2_valid <= s1_valid;
         if (s2_adv && s1_valid) begin
            out_data    <= {s1_sign, asm_exp, asm_mant};
            out_invalid <= asm_inv;
         end
      end
   end

endmodule

// File: tb/tb_fp_upconvert_pipe.sv
// Randomized bench for fp_upconvert_pipe against a real-arithmetic model.
// Honours FP_UPCONVERT_DAZ_EN in its expected values.
module tb_fp_upconvert_pipe;

   logic        clk = 1'b0;
   logic        rst;
   logic [15:0] in_data;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] out_data;
   logic        out_valid;
   logic        out_ready;
   logic        out_invalid;

   int checks = 0;
   int errors = 0;
   int delivered = 0;

   typedef struct {
      logic [31:0] d;
      logic        inv;
   } exp_t;

   exp_t        q[$];
   logic        hold_pending = 1'b0;
   logic [31:0] hold_data;
   logic        hold_inv;

   fp_upconvert_pipe dut (
      .clk(clk),
      .rst(rst),
      .in_data(in_data),
      .in_valid(in_valid),
      .in_ready(in_ready),
      .out_data(out_data),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .out_invalid(out_invalid)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s: got %h want %h", tag, got, want);
      end
   endtask

   // Value of the half as a real, re-encoded through the double format.
   function automatic exp_t ref_conv(input logic [15:0] h);
      logic        s;
      int          e;
      int          m;
      real         r;
      logic [63:0] b;
      exp_t        x;
      s = h[15];
      e = int'(h[14:10]);
      m = int'(h[9:0]);
      x.inv = 1'b0;
      if (e == 31 && m == 0) begin
         x.d = {s, 8'hFF, 23'h0};
      end else if (e == 31) begin
         x.d = {s, 8'hFF, (23'(m) << 13) | 23'h400000};
         x.inv = (m < 512);
      end else if (e == 0 && m == 0) begin
         x.d = {s, 31'h0};
`ifdef FP_UPCONVERT_DAZ_EN
      end else if (e == 0) begin
         x.d = {s, 31'h0};
`endif
      end else begin
         if (e == 0) r = m * 2.0 ** (-24);
         else        r = (1024 + m) * 2.0 ** (e - 25);
         b = $realtobits(r);
         x.d = {s, 8'(int'(b[62:52]) - 1023 + 127), b[51:29]};
      end
      return x;
   endfunction

   function automatic logic [15:0] gen_half();
      logic [15:0] h;
      h = 16'($urandom);
      case ($urandom_range(0, 5))
         0: h[14:0] = 15'h0;
         1: h[14:10] = 5'h0;
         2: h[14:0] = 15'h7C00;
         3: begin
            h[14:10] = 5'h1F;
            if (h[9:0] == 10'h0) h[0] = 1'b1;
         end
         default: ;
      endcase
      return h;
   endfunction

   task automatic tick(input logic v, input logic [15:0] d,
                       input logic ordy, output logic acc);
      @(negedge clk);
      in_valid  = v;
      in_data   = d;
      out_ready = ordy;
      #1;
      if (hold_pending) begin
         check("hold_valid", 32'(out_valid), 32'd1);
         check("hold_data", out_data, hold_data);
         check("hold_inv", 32'(out_invalid), 32'(hold_inv));
      end
      check("in_ready", 32'(in_ready), 32'((q.size() < 2) || ordy));
      if (out_valid && q.size() == 0) begin
         check("spurious_out", 32'(out_valid), 32'd0);
      end else if (out_valid && ordy) begin
         check("out_data", out_data, q[0].d);
         check("out_invalid", 32'(out_invalid), 32'(q[0].inv));
         void'(q.pop_front());
         delivered++;
      end
      hold_pending = out_valid && !ordy;
      hold_data    = out_data;
      hold_inv     = out_invalid;
      acc = v && in_ready;
      if (acc) q.push_back(ref_conv(d));
   endtask

   task automatic directed(input string tag, input logic [15:0] h,
                           input logic [31:0] want, input logic inv);
      logic acc;
      tick(1'b1, h, 1'b1, acc);
      check({tag, "_acc"}, 32'(acc), 32'd1);
      tick(1'b0, 16'h0, 1'b1, acc);
      check({tag, "_lat1"}, 32'(out_valid), 32'd0);
      tick(1'b0, 16'h0, 1'b1, acc);
      check({tag, "_lat2"}, 32'(out_valid), 32'd1);
      check({tag, "_data"}, out_data, want);
      check({tag, "_inv"}, 32'(out_invalid), 32'(inv));
   endtask

   initial begin
      logic        acc;
      logic [15:0] vals[8];
      logic        saw_low;
      int          idx;
      int          cyc;
      int          base;

      rst = 1'b1;
      in_valid = 1'b1;
      in_data = 16'h3C00;
      out_ready = 1'b1;
      repeat (3) @(negedge clk);
      check("rst_valid", 32'(out_valid), 32'd0);
      check("rst_data", out_data, 32'h0);
      check("rst_inv", 32'(out_invalid), 32'd0);
      rst = 1'b0;
      in_valid = 1'b0;
      #1;
      check("rst_in_ready", 32'(in_ready), 32'd1);

      directed("one", 16'h3C00, 32'h3F800000, 1'b0);
`ifdef FP_UPCONVERT_DAZ_EN
      directed("den_min", 16'h0001, 32'h00000000, 1'b0);
      directed("den_neg", 16'h8200, 32'h80000000, 1'b0);
`else
      directed("den_min", 16'h0001, 32'h33800000, 1'b0);
      directed("den_neg", 16'h8200, 32'hB8000000, 1'b0);
`endif
      directed("snan", 16'h7C01, 32'h7FC02000, 1'b1);
      directed("qnan", 16'h7E00, 32'h7FC00000, 1'b0);
      directed("ninf", 16'hFC00, 32'hFF800000, 1'b0);

      for (int i = 0; i < 8; i++) vals[i] = gen_half();
      base = delivered;
      idx = 0;
      cyc = 0;
      saw_low = 1'b0;
      while (idx < 8 && cyc < 40) begin
         tick(1'b1, vals[idx], !(cyc >= 3 && cyc < 6), acc);
         if (!in_ready) saw_low = 1'b1;
         if (acc) idx++;
         cyc++;
      end
      check("stream_accepted", 32'(idx), 32'd8);
      check("stream_in_ready_fell", 32'(saw_low), 32'd1);
      cyc = 0;
      while (q.size() > 0 && cyc < 20) begin
         tick(1'b0, 16'h0, 1'b1, acc);
         cyc++;
      end
      check("stream_delivered", 32'(delivered - base), 32'd8);

      for (int i = 0; i < 3000; i++) begin
         tick($urandom_range(0, 99) < 70, gen_half(),
              $urandom_range(0, 99) < 65, acc);
      end
      cyc = 0;
      while (q.size() > 0 && cyc < 20) begin
         tick(1'b0, 16'h0, 1'b1, acc);
         cyc++;
      end
      check("drain_empty", 32'(q.size()), 32'd0);

      for (int i = 0; i < 3; i++) tick(1'b1, gen_half(), 1'b0, acc);
      check("full_in_ready", 32'(in_ready), 32'd0);
      @(negedge clk);
      rst = 1'b1;
      in_valid = 1'b1;
      in_data = 16'h3C00;
      @(negedge clk);
      rst = 1'b0;
      in_valid = 1'b0;
      #1;
      check("mid_rst_valid", 32'(out_valid), 32'd0);
      check("mid_rst_in_ready", 32'(in_ready), 32'd1);
      q.delete();
      hold_pending = 1'b0;
      for (int i = 0; i < 5; i++) begin
         tick(1'b0, 16'h0, 1'b1, acc);
         check("post_rst_quiet", 32'(out_valid), 32'd0);
      end
      directed("post_rst", 16'hC000, 32'hC0000000, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/fp_upconvert_pipe.md
FP_UPCONVERT_PIPE -- requirements
Module: fp_upconvert_pipe

Interface
REQ-001 SHALL have parameter SRC_EXP, default 5, meaning source exponent width.
REQ-002 SHALL have parameter SRC_MAN, default 10, meaning source stored-mantissa width.
REQ-003 SHALL have parameter DST_EXP, default 8, meaning destination exponent width.
REQ-004 SHALL have parameter DST_MAN, default 23, meaning destination stored-mantissa width.
REQ-005 SHALL define derived widths SRC_W = 1+SRC_EXP+SRC_MAN and DST_W = 1+DST_EXP+DST_MAN.
REQ-006 SHALL have port clk, input, 1 bit, the only clock; all state updates on its rising edge.
REQ-007 SHALL have port rst, input, 1 bit, synchronous active-high reset.
REQ-008 SHALL have port in_data, input, SRC_W bits, source float {sign, exp, mant}.
REQ-009 SHALL have port in_valid, input, 1 bit, in_data is valid this cycle.
REQ-010 SHALL have port in_ready, output, 1 bit, block accepts in_data this cycle.
REQ-011 SHALL have port out_data, output, DST_W bits, converted float.
REQ-012 SHALL have port out_valid, output, 1 bit, out_data and out_invalid are valid.
REQ-013 SHALL have port out_ready, input, 1 bit, downstream accepts out_data this cycle.
REQ-014 SHALL have port out_invalid, output, 1 bit, converted input was a signalling NaN.

Function
REQ-015 SHALL accept a transfer only when in_valid and in_ready are both 1, and deliver one only when out_valid and out_ready are both 1.
REQ-016 SHALL implement two registered stages: S1 = classify, priority-encode leading zeros, register sign/exp/mant/class/shift; S2 = assemble out_data, register it.
REQ-017 SHALL have a latency of exactly 2 cycles from input acceptance to out_valid when out_ready is held at 1.
REQ-018 SHALL advance S2 when S2 is empty or out_ready=1, and advance S1 when S1 is empty or S2 advances.
REQ-019 SHALL drive in_ready = S1 empty OR S2 advances, combinationally, sustaining 1 transfer/cycle with no bubbles.
REQ-020 SHALL hold out_data, out_invalid, and out_valid stable while out_valid=1 and out_ready=0.
REQ-021 SHALL preserve order and lose or duplicate no items under any in_valid/out_ready pattern, including simultaneous accept and deliver with both stages full.
REQ-022 SHALL convert a normal input as: exp_dst = exp_src + (2^(DST_EXP-1) - 2^(SRC_EXP-1)); mant_dst = {mant_src, (DST_MAN-SRC_MAN) zeros}.
REQ-023 SHALL convert a denormal input with lz = leading zeros of mant_src (0..SRC_MAN-1) as: exp_dst = bias_dst - bias_src + 1 - (lz+1); mant_dst = mant_src shifted left lz+1, zero-padded.
REQ-024 SHALL convert a zero input to a signed zero and an infinity input to a signed infinity (exp all ones, mant 0).
REQ-025 SHALL convert a NaN input to: sign kept, exp all ones, payload left-aligned, mant_dst MSB forced 1, out_invalid=1 only if the source mant MSB was 0.
REQ-026 SHALL produce exact results in all cases, with no rounding and no overflow.

Reset
REQ-027 SHALL, on rst=1 at a clock edge, clear both stage valid bits, out_data, and out_invalid to 0, discarding any in-flight items.
REQ-028 SHALL drive in_ready=1 in the first cycle after rst deasserts, and SHALL ignore in_valid during rst.

Configuration
REQ-029 SHALL, when macro FP_UPCONVERT_DAZ_EN is defined, convert denormal inputs to a zero of the same sign (denormals-are-zero) and omit the S1 leading-zero encoder.
REQ-030 SHALL, when FP_UPCONVERT_DAZ_EN is undefined, convert denormals exactly per REQ-023; latency and handshake SHALL be identical in both builds.

Verification (default parameters)
REQ-031 SHALL verify: 0x3C00 accepted, out_ready=1 -> 0x3F800000 two cycles later, out_invalid=0.
REQ-032 SHALL verify: 0x0001 -> 0x33800000, and 0x8200 -> 0xB8000000 (with FP_UPCONVERT_DAZ_EN: 0x00000000 and 0x80000000).
REQ-033 SHALL verify: 0x7C01 -> 0x7FC02000 with out_invalid=1; 0x7E00 -> 0x7FC00000 with out_invalid=0; 0xFC00 -> 0xFF800000.
REQ-034 SHALL verify: stream of 8 back-to-back values with out_ready=0 for 3 cycles mid-stream -> in_ready falls once both stages are full, out_data is held, all 8 results arrive in order with none lost.
REQ-035 SHALL verify: rst pulsed with both stages full -> out_valid=0 next cycle, no stale output afterwards, in_ready=1.
